// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: instruction geometry, halt marker and the
// instruction/PC bundle handed to the IF/ID register.
package fetch_pkg;

    localparam int INSTR_WIDTH    = 32;
    localparam int INSTR_BYTES    = 4;
    localparam int FETCH_PC_WIDTH = 64;

    localparam logic [INSTR_WIDTH-1:0] HALT_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0]    instr;
        logic [FETCH_PC_WIDTH-1:0] pc;
    } fetch_out_t;

endpackage

// File: rtl/fetch_unpack_buffer_sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and full/empty flags.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits, so they wrap without extra logic.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unpack_buffer.sv
// Buffers 64-bit fetch beats and presents them as two 32-bit instructions
// (lower half first) with their PC; handles redirect, misaligned start and halt.
module fetch_unpack_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_valid,
    input  logic [ADDR_WIDTH-1:0]        start_pc,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [INSTR_WIDTH-1:0]       out_instr,
    output logic [ADDR_WIDTH-1:0]        out_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_halt,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    logic [DATA_WIDTH-1:0]  head_beat;
    logic [INSTR_WIDTH-1:0] head_word;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   half_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic                   halt_q;
    logic                   push;
    logic                   pop;
    logic                   out_fire;
    logic                   head_is_halt;
    logic                   unused_start_pc_lsbs;
    fetch_out_t             out_bus;

    // Instructions are word aligned; the two low PC bits carry no information.
    assign unused_start_pc_lsbs = ^start_pc[1:0];

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_beat_fifo (
        .clk   (clk),
        .rst_n (reset),
        .flush (start_valid),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head_beat),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_word    = half_q ? head_beat[2*INSTR_WIDTH-1:INSTR_WIDTH]
                                 : head_beat[INSTR_WIDTH-1:0];
    assign head_is_halt = !fifo_empty && (head_word == HALT_WORD);

    // in_ready depends only on registered state and start_valid, never on out_ready.
    assign in_ready  = reset && !fifo_full && !halt_q && !start_valid;
    assign out_valid = reset && !fifo_empty && !halt_q && !start_valid && !head_is_halt;
    assign push      = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign pop       = out_fire && half_q;

    assign out_bus.instr = head_word;
    assign out_bus.pc    = FETCH_PC_WIDTH'(pc_q);
    assign out_instr     = out_bus.instr;
    assign out_pc        = ADDR_WIDTH'(out_bus.pc);
    assign out_halt      = halt_q;

    // A redirect starting at an odd word begins on the upper half of its first beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            half_q <= 1'b0;
            pc_q   <= '0;
            halt_q <= 1'b0;
        end else if (start_valid) begin
            half_q <= start_pc[2];
            pc_q   <= {start_pc[ADDR_WIDTH-1:2], 2'b00};
            halt_q <= 1'b0;
        end else begin
            if (out_fire) begin
                half_q <= !half_q;
                pc_q   <= pc_q + ADDR_WIDTH'(INSTR_BYTES);
            end
            if (head_is_halt) halt_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unpack_buffer.sv
// Self-checking bench for fetch_unpack_buffer: directed vector table, hand
// sequences for multi-cycle corners and random traffic against a word-queue model.
module tb_fetch_unpack_buffer;

    logic        clk;
    logic        rst;
    logic        sv;
    logic [63:0] spc;
    logic [63:0] din;
    logic        iv;
    logic        in_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_valid;
    logic        ordy;
    logic        out_halt;
    logic [2:0]  count;

    fetch_unpack_buffer #(.DEPTH(4), .DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .clk         (clk),
        .reset       (rst),
        .start_valid (sv),
        .start_pc    (spc),
        .in_data     (din),
        .in_valid    (iv),
        .in_ready    (in_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_valid   (out_valid),
        .out_ready   (ordy),
        .out_halt    (out_halt),
        .count       (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: pending instruction words in stream order. low_gone marks
    // that the head beat has already lost its lower word (consumed or skipped).
    logic [31:0] wq[$];
    bit          low_gone = 0;
    logic [63:0] m_pc     = 0;
    bit          m_halt   = 0;
    int          m_cnt;
    bit          m_ir;
    bit          m_ov;
    logic [31:0] m_head;

    logic [95:0] got_q[$];
    logic [95:0] exp_q[$];
    logic [63:0] src_q[$];

    bit          s_ir;
    bit          s_ov;
    logic [31:0] s_instr;
    logic [63:0] s_pc;
    int          s_cnt;
    bit          s_halt;
    bit          s_accept;

    task automatic model_eval();
        m_cnt  = (wq.size() + int'(low_gone)) / 2;
        m_head = (wq.size() > 0) ? wq[0] : 32'h0;
        m_ir   = rst && (m_cnt < 4) && !m_halt && !sv;
        m_ov   = rst && (wq.size() > 0) && !m_halt && !sv && (m_head != 32'h0);
    endtask

    task automatic model_edge();
        bit zero_head;
        if (!rst) begin
            wq.delete();
            low_gone = 0;
            m_pc     = 0;
            m_halt   = 0;
        end else if (sv) begin
            wq.delete();
            low_gone = spc[2];
            m_pc     = {spc[63:2], 2'b00};
            m_halt   = 0;
        end else begin
            zero_head = (wq.size() > 0) && (m_head == 32'h0);
            if (iv && m_ir) begin
                if (!(wq.size() == 0 && low_gone)) wq.push_back(din[31:0]);
                wq.push_back(din[63:32]);
            end
            if (m_ov && ordy) begin
                void'(wq.pop_front());
                low_gone = !low_gone;
                m_pc     = m_pc + 64'd4;
            end
            if (zero_head) m_halt = 1;
        end
    endtask

    // Entered 1 time unit after a rising edge with inputs already driven.
    task automatic cycle();
        #1;
        model_eval();
        s_ir     = in_ready;
        s_ov     = out_valid;
        s_instr  = out_instr;
        s_pc     = out_pc;
        s_cnt    = int'(count);
        s_halt   = out_halt;
        s_accept = iv && in_ready;
        chk("in_ready",  64'(in_ready),  64'(m_ir));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("count",     64'(count),     64'(m_cnt));
        chk("out_halt",  64'(out_halt),  64'(m_halt));
        chk("out_pc",    out_pc,         m_pc);
        if (m_ov) chk("out_instr", 64'(out_instr), 64'(m_head));
        if (out_valid && ordy) got_q.push_back({out_instr, out_pc});
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    // Drives beats from src_q (held until accepted) for up to max_c cycles,
    // stopping early once want outputs have been collected (want=0: never).
    task automatic run(input int max_c, input int want);
        for (int i = 0; i < max_c; i++) begin
            if (want != 0 && got_q.size() >= want) break;
            iv  = (src_q.size() > 0);
            din = (src_q.size() > 0) ? src_q[0] : 64'h0;
            cycle();
            if (s_accept) void'(src_q.pop_front());
        end
        iv = 1'b0;
    endtask

    task automatic check_stream(input string name);
        chk({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({name, "_instr"}, 64'(got_q[i][95:64]), 64'(exp_q[i][95:64]));
            chk({name, "_pc"},    got_q[i][63:0],       exp_q[i][63:0]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic redirect(input logic [63:0] pc);
        sv  = 1'b1;
        spc = pc;
        cycle();
        sv  = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        bit          sv;
        logic [63:0] spc;
        logic [63:0] din;
        bit          iv;
        bit          ordy;
        bit          e_ir;
        bit          e_ov;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        int          e_cnt;
        bit          e_halt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{0, 0, 64'h0,    64'h0,                   0, 0, 0, 0, 32'h0,        64'h0,    0, 0};
        tbl[1]  = '{1, 0, 64'h0,    64'h0,                   0, 0, 1, 0, 32'h0,        64'h0,    0, 0};
        tbl[2]  = '{1, 1, 64'h1000, 64'h0,                   0, 0, 0, 0, 32'h0,        64'h0,    0, 0};
        tbl[3]  = '{1, 0, 64'h0,    64'h00500093_00100113,   1, 1, 1, 0, 32'h0,        64'h1000, 0, 0};
        tbl[4]  = '{1, 0, 64'h0,    64'h0,                   0, 1, 1, 1, 32'h00100113, 64'h1000, 1, 0};
        tbl[5]  = '{1, 0, 64'h0,    64'h0,                   0, 1, 1, 1, 32'h00500093, 64'h1004, 1, 0};
        tbl[6]  = '{1, 0, 64'h0,    64'h0,                   0, 0, 1, 0, 32'h0,        64'h1008, 0, 0};
        tbl[7]  = '{1, 1, 64'h1000, 64'h0,                   0, 0, 0, 0, 32'h0,        64'h1008, 0, 0};
        tbl[8]  = '{1, 0, 64'h0,    64'h00000000_00100113,   1, 1, 1, 0, 32'h0,        64'h1000, 0, 0};
        tbl[9]  = '{1, 0, 64'h0,    64'h0,                   0, 1, 1, 1, 32'h00100113, 64'h1000, 1, 0};
        tbl[10] = '{1, 0, 64'h0,    64'h0,                   0, 1, 1, 0, 32'h0,        64'h1004, 1, 0};
        tbl[11] = '{1, 0, 64'h0,    64'h0,                   0, 0, 0, 0, 32'h0,        64'h1004, 1, 1};
        tbl[12] = '{1, 1, 64'h3000, 64'h0,                   0, 0, 0, 0, 32'h0,        64'h1004, 1, 1};
        tbl[13] = '{1, 0, 64'h0,    64'h0,                   0, 0, 1, 0, 32'h0,        64'h3000, 0, 0};

        rst  = 1'b0;
        sv   = 1'b0;
        spc  = '0;
        din  = '0;
        iv   = 1'b0;
        ordy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset/idle, basic unpack and halt recovery as a vector table.
        for (int i = 0; i < 14; i++) begin
            rst  = tbl[i].rst;
            sv   = tbl[i].sv;
            spc  = tbl[i].spc;
            din  = tbl[i].din;
            iv   = tbl[i].iv;
            ordy = tbl[i].ordy;
            cycle();
            chk("tbl_in_ready",  64'(s_ir),   64'(tbl[i].e_ir));
            chk("tbl_out_valid", 64'(s_ov),   64'(tbl[i].e_ov));
            chk("tbl_count",     64'(s_cnt),  64'(tbl[i].e_cnt));
            chk("tbl_halt",      64'(s_halt), 64'(tbl[i].e_halt));
            chk("tbl_pc",        s_pc,        tbl[i].e_pc);
            if (tbl[i].e_ov) chk("tbl_instr", 64'(s_instr), 64'(tbl[i].e_instr));
        end
        sv = 1'b0;
        iv = 1'b0;
        got_q.delete();

        // Backpressure: five beats against a four-entry buffer, then drain.
        ordy = 1'b0;
        redirect(64'h1000);
        for (int k = 0; k < 5; k++)
            src_q.push_back({32'h1000_0000 + 32'(2*k + 1), 32'h1000_0000 + 32'(2*k)});
        run(6, 0);
        chk("bp_count",    64'(s_cnt),        64'd4);
        chk("bp_in_ready", 64'(s_ir),         64'd0);
        chk("bp_held",     64'(src_q.size()), 64'd1);
        ordy = 1'b1;
        run(30, 10);
        for (int j = 0; j < 10; j++)
            exp_q.push_back({32'h1000_0000 + 32'(j), 64'h1000 + 64'(4*j)});
        check_stream("bp");
        run(2, 0);
        chk("bp_empty", 64'(s_cnt), 64'd0);

        // Misaligned start skips the lower word of the first beat.
        redirect(64'h2004);
        src_q.push_back(64'hAAAAAAAA_BBBBBBBB);
        src_q.push_back(64'hDDDDDDDD_CCCCCCCC);
        run(12, 3);
        exp_q.push_back({32'hAAAAAAAA, 64'h2004});
        exp_q.push_back({32'hCCCCCCCC, 64'h2008});
        exp_q.push_back({32'hDDDDDDDD, 64'h200C});
        check_stream("misalign");

        // Flush with a beat offered in the same cycle.
        ordy = 1'b0;
        redirect(64'h4000);
        for (int k = 0; k < 3; k++) src_q.push_back(64'h1111_0000_2222_0000 + 64'(k + 1));
        run(4, 0);
        chk("fl_count3", 64'(s_cnt), 64'd3);
        sv  = 1'b1;
        spc = 64'h5000;
        iv  = 1'b1;
        din = 64'h7777_7777_8888_8888;
        cycle();
        chk("fl_in_ready", 64'(s_ir), 64'd0);
        sv = 1'b0;
        iv = 1'b0;
        cycle();
        chk("fl_count0", 64'(s_cnt), 64'd0);
        chk("fl_pc",     s_pc,       64'h5000);

        // Same corner with reset instead of a redirect.
        for (int k = 0; k < 3; k++) src_q.push_back(64'h3333_0000_4444_0000 + 64'(k + 1));
        run(4, 0);
        chk("rs_count3", 64'(s_cnt), 64'd3);
        rst = 1'b0;
        iv  = 1'b1;
        din = 64'h9999_9999_AAAA_AAAA;
        cycle();
        chk("rs_in_ready",  64'(s_ir), 64'd0);
        chk("rs_out_valid", 64'(s_ov), 64'd0);
        rst = 1'b1;
        iv  = 1'b0;
        cycle();
        chk("rs_count0", 64'(s_cnt),  64'd0);
        chk("rs_pc",     s_pc,        64'h0);
        chk("rs_halt",   64'(s_halt), 64'd0);
        src_q.delete();
        got_q.delete();

        // Random traffic with halts, redirects (some near PC wrap) and resets.
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 149) != 0);
            sv  = ($urandom_range(0, 24) == 0);
            spc = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) spc[63:8] = '1;
            iv  = ($urandom_range(0, 2) != 0);
            din = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) din[31:0]  = 32'h0;
            if ($urandom_range(0, 15) == 0) din[63:32] = 32'h0;
            ordy = ($urandom_range(0, 3) != 0);
            cycle();
        end
        got_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unpack_buffer.md
Name: fetch_unpack_buffer

Overview:
Sits between the AXI instruction-fetch engine and the IF/ID pipeline register. It buffers 64-bit read-data beats from the fetch burst and splits each beat into two 32-bit RV64 instructions, lower half first. Each instruction is presented with its PC over a valid/ready handshake. It handles redirect/flush, misaligned start PC, and detection of the all-zero halt word.

Parameters:
DEPTH, 4, beat storage entries (power of two, >=2)
DATA_WIDTH, 64, beat width in bits
ADDR_WIDTH, 64, PC width in bits

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets on clk edge)
start_valid  input  1  redirect/flush strobe
start_pc  input  ADDR_WIDTH  PC of first instruction of new stream; bits [1:0] ignored (treated as 0)
in_data  input  DATA_WIDTH  beat from fetch (rdata)
in_valid  input  1  beat valid (rvalid)
in_ready  output  1  beat accepted when in_valid && in_ready
out_instr  output  32  instruction to IF/ID
out_pc  output  ADDR_WIDTH  PC of out_instr
out_valid  output  1  out_instr/out_pc valid
out_ready  input  1  IF/ID accepts when out_valid && out_ready
out_halt  output  1  sticky: zero instruction word reached head
count  output  $clog2(DEPTH+1)  beats held

Behaviour:
- Reset (reset==0 at edge): FIFO empty, count=0, half=0, pc=0, out_halt=0.
  - While reset==0: in_ready=0 and out_valid=0.
- State:
  - FIFO of beats.
  - half bit selects the head word: 0 -> in_data[31:0], 1 -> [63:32].
  - pc register.
  - halt flag.
- in_ready = (count < DEPTH) && !out_halt && !start_valid. There is no combinational path from out_ready to in_ready.
- out_valid = (count != 0) && !out_halt && !start_valid && (head word != 32'h0).
- out_instr = selected head word; out_pc = pc.
- Latency: a beat accepted at cycle N can be presented at N+1. There is no bypass.
- Output handshake accepted:
  - pc += 4.
  - If half==0: half becomes 1.
  - If half==1: half becomes 0, head beat popped, count decrements.
- Push and pop in the same cycle: count unchanged. Push is only possible if count < DEPTH before the edge; a full FIFO never bypasses.
- Halt: if count!=0 and the selected head word == 32'h0, out_halt sets at the next edge.
  - Once set it stays set and blocks in/out.
  - Only start_valid or reset clears it.
  - pc holds the address of the zero word.
- start_valid (priority over all other activity):
  - FIFO cleared, count=0.
  - pc = {start_pc[ADDR_WIDTH-1:2], 2'b00}.
  - half = start_pc[2], so the lower half of the first beat is discarded when start_pc[2]=1.
  - out_halt cleared.
  - Any beat offered that cycle is not accepted (in_ready=0).
- Wrap-around: read/write pointers are log2(DEPTH) bits and wrap naturally. pc wraps modulo 2^ADDR_WIDTH.
- A beat with in_valid while in_ready=0 must be held by the source. The block does not latch it.

Decomposition:
- Package fetch_pkg holds:
  - INSTR_WIDTH=32.
  - INSTR_BYTES=4.
  - HALT_WORD=32'h0000_0000.
  - Typedef fetch_out_t {instr, pc}, shared with the IF/ID register.
- One sub-module: sync_fifo (parameterised width/depth storage with push/pop/flush, count, full/empty).
- Unpack, pc and halt logic live in fetch_unpack_buffer.

Test Plan:
1. Reset/idle:
   - Hold reset=0 for 2 cycles -> in_ready=0, out_valid=0, count=0, out_halt=0.
   - Release -> in_ready=1, out_valid=0.
2. Basic unpack:
   - start_pc=0x1000, then push beat 0x00500093_00100113 with out_ready=1.
   - Next cycle: out_instr=0x00100113, out_pc=0x1000.
   - Following cycle: 0x00500093 @0x1004, then count=0, out_valid=0.
3. Backpressure/full:
   - out_ready=0, push 5 beats -> count=4, in_ready=0 after the 4th, 5th beat held.
   - Set out_ready=1 -> 10 instructions emitted in order, pc 0x1000..0x1024, no drop or duplicate.
4. Misaligned start:
   - start_pc=0x2004, push 0xAAAAAAAA_BBBBBBBB, 0xDDDDDDDD_CCCCCCCC.
   - Outputs in order: 0xAAAAAAAA@0x2004, 0xCCCCCCCC@0x2008, 0xDDDDDDDD@0x200C.
5. Halt:
   - Push 0x00000000_00100113 -> 0x00100113 emitted, then out_halt=1, out_valid=0, in_ready=0, out_pc=0x1004.
   - start_valid with start_pc=0x3000 -> out_halt=0, count=0, in_ready=1.
6. Flush/reset mid-operation:
   - count=3 with start_valid and in_valid asserted in the same cycle -> beat not accepted, count=0 next cycle.
   - Repeat with reset=0 instead -> count=0, pc=0, out_halt=0.
